// File: rtl/lsu_arb.sv
// Two-requester LSU arbiter: round-robin grant, single-cycle issue, registered load response.
// Optional grant locking is built only when LSU_ARB_LOCK_EN is defined.
module lsu_arb #(
    parameter int MAX_LOCK = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,

    input  logic        i_r0_req,
    input  logic [31:0] i_r0_addr,
    input  logic [31:0] i_r0_wdata,
    input  logic [3:0]  i_r0_bmask,
    input  logic        i_r0_we,
    input  logic        i_r0_unsigned,
    input  logic        i_r0_lock,
    output logic        o_r0_gnt,
    output logic        o_r0_rvalid,
    output logic [31:0] o_r0_rdata,

    input  logic        i_r1_req,
    input  logic [31:0] i_r1_addr,
    input  logic [31:0] i_r1_wdata,
    input  logic [3:0]  i_r1_bmask,
    input  logic        i_r1_we,
    input  logic        i_r1_unsigned,
    input  logic        i_r1_lock,
    output logic        o_r1_gnt,
    output logic        o_r1_rvalid,
    output logic [31:0] o_r1_rdata,

    output logic        o_lsu_instr_valid,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic [3:0]  o_lsu_bytemask,
    output logic        o_lsu_st_en,
    output logic        o_lsu_ld_unsigned,
    input  logic [31:0] i_lsu_ld_data
);

    // Handshake: req acts as valid and gnt as the same-cycle acceptance; a granted
    // access is complete in that cycle, loads answer with a one-cycle rvalid pulse.
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_e;

    last_e       last_q, last_d;
    logic        rr_gnt0, rr_gnt1;
    logic        gnt0, gnt1;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    always_comb begin
        rr_gnt0 = 1'b0;
        rr_gnt1 = 1'b0;
        if (i_r0_req && i_r1_req) begin
            if (last_q == LAST0) begin
                rr_gnt1 = 1'b1;
            end else begin
                rr_gnt0 = 1'b1;
            end
        end else begin
            rr_gnt0 = i_r0_req;
            rr_gnt1 = i_r1_req;
        end
    end

`ifdef LSU_ARB_LOCK_EN
    logic       lock_act_q, lock_act_d;
    logic       lock_own_q, lock_own_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       gnt_lock;
    logic [3:0] cnt_next;

    // An active lock bypasses round-robin: only the owner can be granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rstn) begin
            if (lock_act_q) begin
                if (lock_own_q) begin
                    gnt1 = i_r1_req;
                end else begin
                    gnt0 = i_r0_req;
                end
            end else begin
                gnt0 = rr_gnt0;
                gnt1 = rr_gnt1;
            end
        end
    end

    always_comb begin
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        gnt_lock   = gnt1 ? i_r1_lock : i_r0_lock;
        cnt_next   = (lock_act_q && (lock_own_q == gnt1)) ? lock_cnt_q + 4'd1 : 4'd1;
        if (gnt0 || gnt1) begin
            if (gnt_lock && (cnt_next < 4'(MAX_LOCK))) begin
                lock_act_d = 1'b1;
                lock_own_d = gnt1;
                lock_cnt_d = cnt_next;
            end else begin
                lock_act_d = 1'b0;
                lock_own_d = 1'b0;
                lock_cnt_d = 4'd0;
            end
        end else if (lock_act_q) begin
            // Owner stopped requesting: nothing issued this cycle, lock dropped.
            lock_act_d = 1'b0;
            lock_own_d = 1'b0;
            lock_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
            lock_cnt_q <= 4'd0;
        end else begin
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{i_r0_lock, i_r1_lock, 4'(MAX_LOCK)};

    always_comb begin
        gnt0 = rr_gnt0 & i_rstn;
        gnt1 = rr_gnt1 & i_rstn;
    end
`endif

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = LAST0;
        end else if (gnt1) begin
            last_d = LAST1;
        end
    end

    always_comb begin
        rvalid_d    = 2'b00;
        rvalid_d[0] = gnt0 & ~i_r0_we;
        rvalid_d[1] = gnt1 & ~i_r1_we;
        rdata0_d    = rvalid_d[0] ? i_lsu_ld_data : rdata0_q;
        rdata1_d    = rvalid_d[1] ? i_lsu_ld_data : rdata1_q;
    end

    always_comb begin
        o_lsu_instr_valid = gnt0 | gnt1;
        o_lsu_addr        = 32'd0;
        o_lsu_st_data     = 32'd0;
        o_lsu_bytemask    = 4'd0;
        o_lsu_st_en       = 1'b0;
        o_lsu_ld_unsigned = 1'b0;
        if (gnt0) begin
            o_lsu_addr        = i_r0_addr;
            o_lsu_st_data     = i_r0_wdata;
            o_lsu_bytemask    = i_r0_bmask;
            o_lsu_st_en       = i_r0_we;
            o_lsu_ld_unsigned = i_r0_unsigned;
        end else if (gnt1) begin
            o_lsu_addr        = i_r1_addr;
            o_lsu_st_data     = i_r1_wdata;
            o_lsu_bytemask    = i_r1_bmask;
            o_lsu_st_en       = i_r1_we;
            o_lsu_ld_unsigned = i_r1_unsigned;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            last_q   <= LAST1;
            rvalid_q <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign o_r0_gnt    = gnt0;
    assign o_r1_gnt    = gnt1;
    assign o_r0_rvalid = rvalid_q[0];
    assign o_r1_rvalid = rvalid_q[1];
    assign o_r0_rdata  = rdata0_q;
    assign o_r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_lsu_arb.sv
// Directed self-checking bench for lsu_arb; lock checks follow LSU_ARB_LOCK_EN.
module tb_lsu_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r0_uns = 1'b0, r0_lock = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0;
    logic [3:0]  r0_bmask = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0, r1_uns = 1'b0, r1_lock = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic [3:0]  r1_bmask = '0;
    logic [31:0] ld_data = '0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        lsu_valid, lsu_st_en, lsu_uns;
    logic [31:0] lsu_addr, lsu_st_data;
    logic [3:0]  lsu_bmask;

    int vectors = 0;
    int miscompares = 0;

    lsu_arb #(.MAX_LOCK(4)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_r0_req(r0_req), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .i_r0_bmask(r0_bmask), .i_r0_we(r0_we), .i_r0_unsigned(r0_uns),
        .i_r0_lock(r0_lock), .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid),
        .o_r0_rdata(r0_rdata),
        .i_r1_req(r1_req), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .i_r1_bmask(r1_bmask), .i_r1_we(r1_we), .i_r1_unsigned(r1_uns),
        .i_r1_lock(r1_lock), .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid),
        .o_r1_rdata(r1_rdata),
        .o_lsu_instr_valid(lsu_valid), .o_lsu_addr(lsu_addr),
        .o_lsu_st_data(lsu_st_data), .o_lsu_bytemask(lsu_bmask),
        .o_lsu_st_en(lsu_st_en), .o_lsu_ld_unsigned(lsu_uns),
        .i_lsu_ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_r0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] bmask, input logic we, input logic uns,
                          input logic lock);
        r0_req = req; r0_addr = addr; r0_wdata = wdata;
        r0_bmask = bmask; r0_we = we; r0_uns = uns; r0_lock = lock;
    endtask

    task automatic set_r1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] bmask, input logic we, input logic uns,
                          input logic lock);
        r1_req = req; r1_addr = addr; r1_wdata = wdata;
        r1_bmask = bmask; r1_we = we; r1_uns = uns; r1_lock = lock;
    endtask

    // Drive happens at negedge; this samples combinational outputs then moves past the edge.
    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        #1;
        chk({tag, "_gnt0"}, {31'd0, r0_gnt}, {31'd0, g0});
        chk({tag, "_gnt1"}, {31'd0, r1_gnt}, {31'd0, g1});
        chk({tag, "_valid"}, {31'd0, lsu_valid}, {31'd0, g0 | g1});
    endtask

    task automatic edge_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesting: no grant may leak out.
        @(negedge clk);
        set_r0(1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        set_r1(1'b1, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk_gnt("rst_req", 1'b0, 1'b0);
        edge_next();
        @(negedge clk);
        edge_next();
        chk("rst_rvalid0", {31'd0, r0_rvalid}, 32'd0);
        chk("rst_rvalid1", {31'd0, r1_rvalid}, 32'd0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);

        // Strict alternation starting at r0.
        @(negedge clk);
        rstn = 1'b1;
        ld_data = 32'hA000_0000;
        chk_gnt("alt_c0", 1'b1, 1'b0);
        chk("alt_c0_addr", lsu_addr, 32'h0000_0100);
        edge_next();
        chk("alt_c0_rv0", {31'd0, r0_rvalid}, 32'd1);
        chk("alt_c0_rd0", r0_rdata, 32'hA000_0000);
        chk("alt_c0_rv1", {31'd0, r1_rvalid}, 32'd0);
        @(negedge clk);
        ld_data = 32'hA000_0001;
        chk_gnt("alt_c1", 1'b0, 1'b1);
        chk("alt_c1_addr", lsu_addr, 32'h0000_0200);
        edge_next();
        chk("alt_c1_rv1", {31'd0, r1_rvalid}, 32'd1);
        chk("alt_c1_rd1", r1_rdata, 32'hA000_0001);
        chk("alt_c1_rv0", {31'd0, r0_rvalid}, 32'd0);
        chk("alt_c1_hold0", r0_rdata, 32'hA000_0000);
        @(negedge clk);
        ld_data = 32'hA000_0002;
        chk_gnt("alt_c2", 1'b1, 1'b0);
        edge_next();
        chk("alt_c2_rd0", r0_rdata, 32'hA000_0002);

        // r1 alone, twice in a row (pointer irrelevant), second load unsigned.
        @(negedge clk);
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        set_r1(1'b1, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        ld_data = 32'hDEAD_BEEF;
        chk_gnt("r1_ld", 1'b0, 1'b1);
        chk("r1_ld_addr", lsu_addr, 32'h0000_0010);
        chk("r1_ld_sten", {31'd0, lsu_st_en}, 32'd0);
        edge_next();
        chk("r1_ld_rv1", {31'd0, r1_rvalid}, 32'd1);
        chk("r1_ld_rd1", r1_rdata, 32'hDEAD_BEEF);
        chk("r1_ld_rv0", {31'd0, r0_rvalid}, 32'd0);
        @(negedge clk);
        set_r1(1'b1, 32'h0000_0014, 32'h0, 4'h3, 1'b0, 1'b1, 1'b0);
        ld_data = 32'hCAFE_F00D;
        chk_gnt("r1_b2b", 1'b0, 1'b1);
        chk("r1_b2b_uns", {31'd0, lsu_uns}, 32'd1);
        chk("r1_b2b_bm", {28'd0, lsu_bmask}, 32'h3);
        edge_next();
        chk("r1_b2b_rv1", {31'd0, r1_rvalid}, 32'd1);
        chk("r1_b2b_rd1", r1_rdata, 32'hCAFE_F00D);

        // r0 store: presented for one cycle, no response, rdata kept.
        @(negedge clk);
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        set_r0(1'b1, 32'h1000_0000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b0);
        ld_data = 32'h0BAD_0BAD;
        chk_gnt("st", 1'b1, 1'b0);
        chk("st_en", {31'd0, lsu_st_en}, 32'd1);
        chk("st_data", lsu_st_data, 32'h1234_5678);
        chk("st_addr", lsu_addr, 32'h1000_0000);
        chk("st_bm", {28'd0, lsu_bmask}, 32'hF);
        edge_next();
        chk("st_rv0", {31'd0, r0_rvalid}, 32'd0);
        chk("st_rd0", r0_rdata, 32'hA000_0002);
        @(negedge clk);
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk_gnt("idle", 1'b0, 1'b0);
        chk("idle_sten", {31'd0, lsu_st_en}, 32'd0);
        chk("idle_addr", lsu_addr, 32'd0);
        chk("idle_stdata", lsu_st_data, 32'd0);
        edge_next();

        // Load granted, then reset the following cycle drops the response.
        @(negedge clk);
        set_r0(1'b1, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        ld_data = 32'h55AA_55AA;
        chk_gnt("pre_rst", 1'b1, 1'b0);
        edge_next();
        @(negedge clk);
        rstn = 1'b0;
        set_r1(1'b1, 32'h0000_0080, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk_gnt("in_rst", 1'b0, 1'b0);
        chk("in_rst_rv0", {31'd0, r0_rvalid}, 32'd1);
        edge_next();
        chk("post_rst_rv0", {31'd0, r0_rvalid}, 32'd0);
        chk("post_rst_rd0", r0_rdata, 32'd0);
        chk("post_rst_rd1", r1_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        chk_gnt("resume", 1'b1, 1'b0);
        edge_next();
        @(negedge clk);
        rstn = 1'b0;
        edge_next();

        // Lock phase: r0 asserts lock, r1 requests continuously.
        @(negedge clk);
        rstn = 1'b1;
        set_r0(1'b1, 32'h0000_0300, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1);
`ifdef LSU_ARB_LOCK_EN
        for (int c = 1; c <= 4; c++) begin
            chk_gnt($sformatf("lock_c%0d", c), 1'b1, 1'b0);
            edge_next();
            @(negedge clk);
        end
        chk_gnt("lock_c5", 1'b0, 1'b1);
        edge_next();
        @(negedge clk);
        chk_gnt("lock_re", 1'b1, 1'b0);
        edge_next();
        @(negedge clk);
        r0_req = 1'b0;
        chk_gnt("lock_drop", 1'b0, 1'b0);
        edge_next();
        @(negedge clk);
        chk_gnt("lock_after", 1'b0, 1'b1);
        edge_next();
`else
        chk_gnt("nolock_c1", 1'b1, 1'b0);
        edge_next();
        @(negedge clk);
        chk_gnt("nolock_c2", 1'b0, 1'b1);
        edge_next();
        @(negedge clk);
        chk_gnt("nolock_c3", 1'b1, 1'b0);
        edge_next();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_arb.md
LSU_ARB -- requirements
Module: lsu_arb

Interface
REQ-001 Parameter: MAX_LOCK, default 4, maximum number of consecutive grants one requester may hold while asserting lock (range 1..15).
REQ-002 Port: i_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: i_rstn  in  1  reset, synchronous, active-low.
REQ-004 Ports, per requester N in {0,1}: i_rN_req in 1 request; i_rN_addr in 32; i_rN_wdata in 32; i_rN_bmask in 4; i_rN_we in 1 store enable; i_rN_unsigned in 1 unsigned load; i_rN_lock in 1 hold grant.
REQ-005 Ports, per requester N: o_rN_gnt out 1 access issued this cycle; o_rN_rvalid out 1 response valid; o_rN_rdata out 32 load data.
REQ-006 LSU-side ports: o_lsu_instr_valid out 1; o_lsu_addr out 32; o_lsu_st_data out 32; o_lsu_bytemask out 4; o_lsu_st_en out 1; o_lsu_ld_unsigned out 1; i_lsu_ld_data in 32 (combinational load data).

Function
REQ-007 At most one of o_r0_gnt and o_r1_gnt SHALL be high in any cycle; a grant SHALL only be given to a requester whose req is high.
REQ-008 Grant SHALL be combinational from the current requests and the registered state; the granted request SHALL complete in the same cycle (no ready wait).
REQ-009 o_lsu_instr_valid SHALL equal o_r0_gnt | o_r1_gnt; the LSU-side outputs SHALL carry the granted requester's fields; with no grant, every LSU-side output SHALL be 0.
REQ-010 o_lsu_st_en SHALL equal the granted requester's we; a store SHALL never be presented without o_lsu_instr_valid.
REQ-011 The arbiter SHALL hold a last-grant pointer, LAST0 or LAST1, updated on every grant.
REQ-012 With both requests high and no lock active, the arbiter SHALL grant the requester that is not the last-grant pointer (round-robin).
REQ-013 With only one request high, the arbiter SHALL grant that requester regardless of the pointer.
REQ-014 On a granted load (we=0), the arbiter SHALL register i_lsu_ld_data into o_rN_rdata of the granted requester. o_rN_rvalid SHALL be high for exactly the next cycle (latency 1).
REQ-015 On a granted store, the arbiter SHALL leave rvalid low and o_rN_rdata unchanged.
REQ-016 o_rN_rdata SHALL hold its value until the next load response to that requester.
REQ-017 Back-to-back grants to the same requester SHALL produce back-to-back rvalid pulses; responses SHALL return in grant order.

Reset
REQ-018 While i_rstn is low at a clock edge, the arbiter SHALL set the pointer to LAST1 (so r0 wins the first tie), clear the lock state and lock counter, and clear o_rN_rvalid and o_rN_rdata to 0.
REQ-019 While reset is asserted, no grant SHALL be issued and o_lsu_instr_valid SHALL be 0.
REQ-020 If reset is asserted in the cycle after a load grant, o_rN_rvalid SHALL be 0 the following cycle; the response is dropped.

Configuration
REQ-021 Macro LSU_ARB_LOCK_EN SHALL control the lock feature.
REQ-022 Without LSU_ARB_LOCK_EN: i_rN_lock SHALL be ignored, no lock state or counter SHALL be built, and arbitration SHALL be pure round-robin.
REQ-023 With LSU_ARB_LOCK_EN, a lock SHALL become active for N when N is granted with i_rN_lock high. While active, N SHALL win every cycle it requests and the other requester SHALL be blocked.
REQ-024 With LSU_ARB_LOCK_EN, a counter SHALL count consecutive locked grants. The lock SHALL release when the owner drops lock or req, or when the count reaches MAX_LOCK. After a MAX_LOCK release, the other requester, if requesting, SHALL win the next cycle.
REQ-025 With LSU_ARB_LOCK_EN, while a lock is active and the owner's req is low, the arbiter SHALL issue no grant that cycle and the lock SHALL release.

Verification
REQ-026 Reset, then r0 and r1 request together: r0 granted in cycle 0, r1 in cycle 1, r0 in cycle 2 (strict alternation).
REQ-027 r1 alone loads addr 0x0000_0010 with i_lsu_ld_data=0xDEAD_BEEF: o_r1_gnt=1 and o_lsu_addr=0x10 the same cycle; next cycle o_r1_rvalid=1 and o_r1_rdata=0xDEADBEEF; o_r0_rvalid stays 0.
REQ-028 r0 stores 0x1234_5678 with bmask 4'hF to 0x1000_0000: o_lsu_st_en=1 and o_lsu_st_data=0x12345678 for one cycle; no rvalid follows.
REQ-029 LSU_ARB_LOCK_EN with MAX_LOCK=4: r0 requests with lock and r1 requests continuously: r0 granted 4 cycles, r1 granted cycle 5, and o_r1_gnt is never high during cycles 1-4.
REQ-030 A load is granted, then i_rstn is driven low next cycle: o_rN_rvalid=0 and o_rN_rdata=0 after the reset edge; arbitration resumes with r0 priority.
